// File: rtl/r_pipe_skid.sv
// r_pipe_skid: one pipeline stage with an optional second (skid) entry.
// SKID_EN=1 gives two entries, so up_ready depends only on registered
// occupancy and never on dn_ready. SKID_EN=0 gives a single register whose
// up_ready looks through to dn_ready. flush empties the stage. rdy_in=0
// freezes every register.
module r_pipe_skid #(
  parameter int                 DATA_W     = 102,
  parameter bit                 SKID_EN    = 1'b1,
  parameter logic [DATA_W-1:0]  BUBBLE_VAL = '0
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              flush_in,
  input  logic              up_valid,
  input  logic [DATA_W-1:0] up_data,
  output logic              up_ready,
  output logic              dn_valid,
  output logic [DATA_W-1:0] dn_data,
  input  logic              dn_ready,
  output logic [1:0]        occ_out,
  output logic              flushed_out
);

  logic [DATA_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic [1:0]        occ_q, occ_d;
  logic              flushed_q, flushed_d;
  logic              room;
  logic              push, pop;

  // Space test: the skid variant decides from occupancy alone; the plain
  // register may also accept while its head is leaving this cycle.
  generate
    if (SKID_EN) begin : g_skid
      assign room = (occ_q != 2'd2);
    end else begin : g_plain
      assign room = (occ_q == 2'd0) | dn_ready;
    end
  endgenerate

  assign up_ready = ~rst_in & rdy_in & ~flush_in & room;
  assign push     = up_valid & up_ready;
  // Flush takes priority, so it suppresses the pop.
  assign pop      = (occ_q != 2'd0) & dn_ready & rdy_in & ~flush_in;

  assign dn_valid    = (occ_q != 2'd0);
  assign dn_data     = head_q;
  assign occ_out     = occ_q;
  assign flushed_out = flushed_q;

  // Next-state: flush empties the stage, rdy_in=0 holds everything,
  // otherwise apply push/pop to the head/skid pair.
  always_comb begin
    head_d    = head_q;
    skid_d    = skid_q;
    occ_d     = occ_q;
    flushed_d = flushed_q;
    if (flush_in) begin
      head_d    = BUBBLE_VAL;
      skid_d    = BUBBLE_VAL;
      occ_d     = 2'd0;
      flushed_d = 1'b1;
    end else if (rdy_in) begin
      flushed_d = 1'b0;
      case (occ_q)
        2'd0: begin
          if (push) begin
            head_d = up_data;
            occ_d  = 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            head_d = up_data;
          end else if (push) begin
            skid_d = up_data;
            occ_d  = 2'd2;
          end else if (pop) begin
            head_d = BUBBLE_VAL;
            occ_d  = 2'd0;
          end
        end
        2'd2: begin
          if (pop) begin
            head_d = skid_q;
            skid_d = BUBBLE_VAL;
            occ_d  = 2'd1;
          end
        end
        default: begin
          head_d = BUBBLE_VAL;
          skid_d = BUBBLE_VAL;
          occ_d  = 2'd0;
        end
      endcase
    end
  end

  // State registers; reset wins over flush and rdy_in.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head_q    <= BUBBLE_VAL;
      skid_q    <= BUBBLE_VAL;
      occ_q     <= 2'd0;
      flushed_q <= 1'b0;
    end else begin
      head_q    <= head_d;
      skid_q    <= skid_d;
      occ_q     <= occ_d;
      flushed_q <= flushed_d;
    end
  end

endmodule

// File: tb/tb_r_pipe_skid.sv
// Bench for r_pipe_skid: one skid instance (SKID_EN=1) and one plain
// instance (SKID_EN=0). Both are checked against a queue-based reference.
module tb_r_pipe_skid;
  localparam int DW = 102;
  localparam int OW = DW + 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, rdy, flush;
  logic uv, dr, ur, dv, fl;
  logic [DW-1:0] ud, dd;
  logic [1:0] occ;
  logic uv0, dr0, ur0, dv0, fl0;
  logic [DW-1:0] ud0, dd0;
  logic [1:0] occ0;

  r_pipe_skid #(.DATA_W(DW), .SKID_EN(1'b1), .BUBBLE_VAL('0)) u_dut (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .flush_in(flush),
    .up_valid(uv), .up_data(ud), .up_ready(ur),
    .dn_valid(dv), .dn_data(dd), .dn_ready(dr),
    .occ_out(occ), .flushed_out(fl));

  r_pipe_skid #(.DATA_W(DW), .SKID_EN(1'b0), .BUBBLE_VAL('0)) u_dut0 (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .flush_in(flush),
    .up_valid(uv0), .up_data(ud0), .up_ready(ur0),
    .dn_valid(dv0), .dn_data(dd0), .dn_ready(dr0),
    .occ_out(occ0), .flushed_out(fl0));

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: a FIFO queue per instance plus the flushed flag.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] mq0[$];
  logic mfl, mfl0;

  function automatic logic [OW-1:0] exp1();
    int n = mq.size();
    return {1'(n != 0), 2'(n), mfl, (n != 0) ? mq[0] : {DW{1'b0}}};
  endfunction

  function automatic logic [OW-1:0] exp0();
    int n = mq0.size();
    return {1'(n != 0), 2'(n), mfl0, (n != 0) ? mq0[0] : {DW{1'b0}}};
  endfunction

  function automatic logic exp_ur1();
    return !rst && rdy && !flush && (mq.size() < 2);
  endfunction

  function automatic logic exp_ur0();
    return !rst && rdy && !flush && (mq0.size() == 0 || dr0);
  endfunction

  // One clock edge: advance the model with the inputs that are held across
  // the edge, then settle past the edge.
  task automatic edge_step();
    bit p, q;
    logic [DW-1:0] tmp;
    @(posedge clk);
    if (rst) begin
      mq.delete(); mq0.delete(); mfl = 1'b0; mfl0 = 1'b0;
    end else if (flush) begin
      mq.delete(); mq0.delete(); mfl = 1'b1; mfl0 = 1'b1;
    end else if (rdy) begin
      mfl = 1'b0; mfl0 = 1'b0;
      p = uv && mq.size() < 2;
      q = dr && mq.size() > 0;
      if (q) tmp = mq.pop_front();
      if (p) mq.push_back(ud);
      p = uv0 && (mq0.size() == 0 || dr0);
      q = dr0 && mq0.size() > 0;
      if (q) tmp = mq0.pop_front();
      if (p) mq0.push_back(ud0);
    end
    #1;
  endtask

  task automatic idle_inputs();
    rst = 0; rdy = 1; flush = 0;
    uv = 0; dr = 0; ud = '0;
    uv0 = 0; dr0 = 0; ud0 = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    edge_step();
    rst = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1; uv = 1; ud = DW'('h33); uv0 = 1; flush = 1;
    #1;
    n_cmp++;
    if (ur !== 1'b0 || ur0 !== 1'b0) begin
      n_bad++; $display("FAIL reset_up_ready got %b/%b need 0/0", ur, ur0);
    end
    edge_step(); edge_step();
    n_cmp++;
    if ({dv, occ, fl, dd} !== {1'b0, 2'd0, 1'b0, {DW{1'b0}}}) begin
      n_bad++; $display("FAIL reset_state got v%b occ%0d fl%b d%h", dv, occ, fl, dd);
    end
    idle_inputs();
  endtask

  task automatic test_single();
    do_reset();
    uv = 1; ud = DW'('hA1); dr = 1;
    edge_step();
    uv = 0; dr = 0;
    n_cmp++;
    if ({dv, occ, fl, dd} !== {1'b1, 2'd1, 1'b0, DW'('hA1)}) begin
      n_bad++; $display("FAIL single_push got v%b occ%0d d%h need v1 occ1 dA1", dv, occ, dd);
    end
  endtask

  task automatic test_skid_fill();
    do_reset();
    dr = 0; uv = 1; ud = DW'('hA1);
    edge_step();
    ud = DW'('hA2);
    edge_step();
    uv = 0;
    #1;
    n_cmp++;
    if (occ !== 2'd2 || ur !== 1'b0 || dd !== DW'('hA1)) begin
      n_bad++; $display("FAIL skid_full got occ%0d ur%b d%h need occ2 ur0 dA1", occ, ur, dd);
    end
    dr = 1;
    edge_step();
    n_cmp++;
    if ({dv, occ, dd} !== {1'b1, 2'd1, DW'('hA2)}) begin
      n_bad++; $display("FAIL skid_pop1 got v%b occ%0d d%h need v1 occ1 dA2", dv, occ, dd);
    end
    edge_step();
    n_cmp++;
    if ({dv, occ, dd} !== {1'b0, 2'd0, {DW{1'b0}}}) begin
      n_bad++; $display("FAIL skid_pop2 got v%b occ%0d d%h need v0 occ0 d0", dv, occ, dd);
    end
    dr = 0;
  endtask

  task automatic test_flush();
    do_reset();
    uv = 1; ud = DW'('hB1); edge_step();
    ud = DW'('hB2); edge_step();
    flush = 1; dr = 1; ud = DW'('hB3);
    edge_step();
    n_cmp++;
    if ({dv, occ, fl, dd} !== {1'b0, 2'd0, 1'b1, {DW{1'b0}}}) begin
      n_bad++; $display("FAIL flush_first got v%b occ%0d fl%b d%h need empty fl1", dv, occ, fl, dd);
    end
    rdy = 0;
    edge_step();
    n_cmp++;
    if ({dv, occ, fl} !== {1'b0, 2'd0, 1'b1}) begin
      n_bad++; $display("FAIL flush_second got v%b occ%0d fl%b need empty fl1", dv, occ, fl);
    end
    flush = 0; uv = 0;
    edge_step();
    n_cmp++;
    if (fl !== 1'b1) begin
      n_bad++; $display("FAIL flushed_hold got %b need 1", fl);
    end
    rdy = 1;
    edge_step();
    n_cmp++;
    if (fl !== 1'b0) begin
      n_bad++; $display("FAIL flushed_clear got %b need 0", fl);
    end
    dr = 0;
  endtask

  task automatic test_freeze();
    do_reset();
    uv = 1; ud = DW'('h55); edge_step();
    rdy = 0; dr = 1; ud = DW'('h66);
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if (ur !== 1'b0) begin
        n_bad++; $display("FAIL freeze_up_ready cyc%0d got %b need 0", i, ur);
      end
      edge_step();
      n_cmp++;
      if ({dv, occ, fl, dd} !== {1'b1, 2'd1, 1'b0, DW'('h55)}) begin
        n_bad++; $display("FAIL freeze_state cyc%0d got v%b occ%0d d%h need v1 occ1 d55", i, dv, occ, dd);
      end
    end
    idle_inputs();
  endtask

  task automatic test_plain_stream();
    logic [DW-1:0] got[$];
    int nxt = 1;
    int cyc = 0;
    bit ok = 1;
    do_reset();
    dr0 = 0;
    while (got.size() < 8 && cyc < 60) begin
      uv0 = (nxt <= 8); ud0 = DW'(nxt);
      #1;
      if (dv0 && dr0) got.push_back(dd0);
      if (occ0 == 2'd2) ok = 0;
      if (uv0 && ur0) nxt++;
      edge_step();
      dr0 = ~dr0;
      cyc++;
    end
    uv0 = 0; dr0 = 0;
    n_cmp++;
    if (!ok) begin
      n_bad++; $display("FAIL plain_occ got occ0=2 need <=1");
    end
    n_cmp++;
    if (got.size() != 8) begin
      n_bad++; $display("FAIL plain_count got %0d need 8", got.size());
    end
    for (int i = 0; i < got.size(); i++) begin
      n_cmp++;
      if (got[i] !== DW'(i + 1)) begin
        n_bad++; $display("FAIL plain_order idx%0d got %h need %h", i, got[i], DW'(i + 1));
      end
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    uv = 1; ud = DW'('hC1); edge_step();
    ud = DW'('hC2); edge_step();
    flush = 1; rst = 1;
    edge_step();
    n_cmp++;
    if ({dv, occ, fl, dd} !== {1'b0, 2'd0, 1'b0, {DW{1'b0}}}) begin
      n_bad++; $display("FAIL reset_mid got v%b occ%0d fl%b d%h need empty fl0", dv, occ, fl, dd);
    end
    flush = 0; rst = 0; ud = DW'('h77); dr = 0;
    edge_step();
    uv = 0;
    n_cmp++;
    if ({dv, occ, dd} !== {1'b1, 2'd1, DW'('h77)}) begin
      n_bad++; $display("FAIL reset_first_push got v%b occ%0d d%h need v1 occ1 d77", dv, occ, dd);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      rst   = ($urandom_range(0, 59) == 0);
      flush = ($urandom_range(0, 11) == 0);
      rdy   = ($urandom_range(0, 3) != 0);
      uv    = $urandom_range(0, 1);
      dr    = ($urandom_range(0, 2) != 0);
      ud    = {$urandom, $urandom, $urandom, $urandom};
      uv0   = $urandom_range(0, 1);
      dr0   = $urandom_range(0, 1);
      ud0   = {$urandom, $urandom, $urandom, $urandom};
      #1;
      n_cmp++;
      if (ur !== exp_ur1() || ur0 !== exp_ur0()) begin
        n_bad++; $display("FAIL rand_up_ready cyc%0d got %b/%b need %b/%b", i, ur, ur0, exp_ur1(), exp_ur0());
      end
      edge_step();
      n_cmp++;
      if ({dv, occ, fl, dd} !== exp1()) begin
        n_bad++; $display("FAIL rand_skid cyc%0d got %h need %h", i, {dv, occ, fl, dd}, exp1());
      end
      n_cmp++;
      if ({dv0, occ0, fl0, dd0} !== exp0()) begin
        n_bad++; $display("FAIL rand_plain cyc%0d got %h need %h", i, {dv0, occ0, fl0, dd0}, exp0());
      end
    end
    idle_inputs();
  endtask

  initial begin
    mfl = 0; mfl0 = 0;
    idle_inputs();
    test_reset();
    test_single();
    test_skid_fill();
    test_flush();
    test_freeze();
    test_plain_stream();
    test_reset_midflight();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/r_pipe_skid.md
R_PIPE_SKID -- requirements
Module: r_pipe_skid

Interface
REQ-001 Parameter DATA_W, default 102, width of the stage payload (we + w_addr + w_data + opcode + mem_addr).
REQ-002 Parameter SKID_EN, default 1: 1 = two-entry skid stage, 0 = single-entry plain pipeline register.
REQ-003 Parameter BUBBLE_VAL, default 0 (DATA_W bits), payload value presented while the stage is empty or flushed.
REQ-004 clk_in  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_in  input  1  reset, synchronous, active-high.
REQ-006 rdy_in  input  1  global chip-ready; low freezes all transfers.
REQ-007 flush_in  input  1  discard all held entries (pipeline bubble insertion).
REQ-008 up_valid  input  1  upstream payload valid.
REQ-009 up_data  input  DATA_W  upstream payload.
REQ-010 up_ready  output  1  stage accepts up_data this cycle.
REQ-011 dn_valid  output  1  head entry valid.
REQ-012 dn_data  output  DATA_W  head entry payload.
REQ-013 dn_ready  input  1  downstream consumes the head this cycle.
REQ-014 occ_out  output  2  current entry count, 0..2.
REQ-015 flushed_out  output  1  registered, high the cycle after a flush was taken.

Function
REQ-016 push = up_valid & up_ready; pop = dn_valid & dn_ready & rdy_in; flush_in outranks both.
REQ-017 dn_valid SHALL equal (occ_out != 0); dn_data SHALL equal the head register, which holds BUBBLE_VAL whenever occ_out = 0.
REQ-018 SKID_EN=1: up_ready = rdy_in & !flush_in & (occ_out != 2); no combinational path from dn_ready to up_ready.
REQ-019 SKID_EN=0: up_ready = rdy_in & !flush_in & ((occ_out == 0) | dn_ready); occ_out never exceeds 1.
REQ-020 Latency: a pushed payload appears on dn_data/dn_valid one cycle after the push edge when the stage was empty or popping.
REQ-021 Ordering strictly FIFO; no payload duplicated or dropped except by flush.
REQ-022 Transitions (SKID_EN=1, rdy_in=1, no flush):
 - occ 0: push -> head=up_data, occ 1.
 - occ 1: push&pop -> head=up_data, occ 1; push only -> skid=up_data, occ 2; pop only -> head=BUBBLE_VAL, occ 0.
 - occ 2: pop -> head=skid, skid=BUBBLE_VAL, occ 1; push impossible (up_ready=0).
REQ-023 flush_in=1, regardless of rdy_in: next edge head=skid=BUBBLE_VAL, occ 0, flushed_out=1; the same-cycle push and pop SHALL NOT occur.
REQ-024 flushed_out SHALL be 0 on any edge where flush_in=0 and rdy_in=1; with rdy_in=0 and no flush it SHALL hold its value.
REQ-025 rdy_in=0 and flush_in=0: all registers hold, up_ready=0, dn_valid/dn_data unchanged, dn_ready ignored.
REQ-026 Consecutive flush cycles keep the stage empty with flushed_out=1 each following cycle.

Reset
REQ-027 rst_in=1 at a rising edge outranks flush_in and rdy_in: head=skid=BUBBLE_VAL, occ_out=0, dn_valid=0, flushed_out=0.
REQ-028 Reset asserted mid-transfer (occ 1 or 2) SHALL discard all entries; the first push after reset release lands in head.
REQ-029 While rst_in=1, up_ready SHALL be 0.

Verification
REQ-030 Reset, then push 0xA1 with dn_ready=1 -> next cycle dn_valid=1, dn_data=0xA1, occ_out=1.
REQ-031 dn_ready=0, push 0xA1 then 0xA2 (SKID_EN=1) -> occ_out=2, up_ready=0; raise dn_ready -> pops 0xA1 then 0xA2 on consecutive cycles, then dn_valid=0, dn_data=0.
REQ-032 occ_out=2, assert flush_in with up_valid=1 and dn_ready=1 -> next cycle occ_out=0, dn_data=0, flushed_out=1, nothing pushed or popped.
REQ-033 occ_out=1 holding 0x55, rdy_in=0 for 3 cycles with up_valid=1, dn_ready=1 -> state unchanged, up_ready=0, dn_data=0x55 throughout.
REQ-034 SKID_EN=0, streaming 0x01..0x08 with dn_ready toggling every cycle -> downstream receives 0x01..0x08 in order, occ_out never 2.
REQ-035 rst_in pulsed while occ_out=2 and flush_in=1 -> next cycle occ_out=0, flushed_out=0.
